// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the LED panel frame buffer.
// RMW states exist only when FRAME_BUFFER_RMW_EN is defined.
package frame_buffer_pkg;

   function automatic int unsigned bits_for(input int unsigned value);
      int unsigned bits;
      bits = 1;
      for (int unsigned i = 1; i < 32; i++)
         if ((value >> i) != 0) bits = i + 1;
      return bits;
   endfunction

   typedef enum logic [1:0] {
      ST_CLEAR  = 2'd0,
      ST_IDLE   = 2'd1
`ifdef FRAME_BUFFER_RMW_EN
      ,
      ST_RMW_RD = 2'd2,
      ST_RMW_WR = 2'd3
`endif
   } state_e;

   typedef enum logic [1:0] {
      OP_REPLACE = 2'b00,
      OP_OR      = 2'b01,
      OP_ANDN    = 2'b10,
      OP_XOR     = 2'b11
   } wr_op_e;

   // Pixel word is packed {b,g,r}, each slice COLOR_DEPTH bits wide.
   typedef enum int unsigned {
      CH_R = 0,
      CH_G = 1,
      CH_B = 2
   } channel_e;

   function automatic int unsigned ch_lsb(input channel_e ch, input int unsigned depth);
      return ch * depth;
   endfunction

endpackage

// File: rtl/frame_buffer_if.sv
// Write, clear and scan-read bundle of the frame buffer.
// i_wr_op is present only when FRAME_BUFFER_RMW_EN is defined.
interface frame_buffer_if #(
   parameter int unsigned COLS        = 32,
   parameter int unsigned ROWS        = 16,
   parameter int unsigned COLOR_DEPTH = 1
);
   import frame_buffer_pkg::*;

   localparam int unsigned COL_BITS     = bits_for(COLS - 1);
   localparam int unsigned ROW_BITS     = bits_for(ROWS - 1);
   localparam int unsigned ADDRESS_BITS = bits_for(ROWS / 2 - 1);
   localparam int unsigned PIX_W        = 3 * COLOR_DEPTH;

   logic                    i_wr_valid;
   logic                    o_wr_ready;
   logic [COL_BITS-1:0]     i_wr_x;
   logic [ROW_BITS-1:0]     i_wr_y;
   logic [PIX_W-1:0]        i_wr_rgb;
`ifdef FRAME_BUFFER_RMW_EN
   wr_op_e                  i_wr_op;
`endif
   logic                    i_clear;
   logic                    o_busy;
   logic                    i_rd_en;
   logic [ADDRESS_BITS-1:0] i_rd_address;
   logic [COL_BITS-1:0]     i_rd_col;
   logic [PIX_W-1:0]        o_rd_rgb_0;
   logic [PIX_W-1:0]        o_rd_rgb_1;

   modport slave (
`ifdef FRAME_BUFFER_RMW_EN
      input  i_wr_op,
`endif
      input  i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_clear,
      input  i_rd_en, i_rd_address, i_rd_col,
      output o_wr_ready, o_busy, o_rd_rgb_0, o_rd_rgb_1
   );

   modport master (
`ifdef FRAME_BUFFER_RMW_EN
      output i_wr_op,
`endif
      output i_wr_valid, i_wr_x, i_wr_y, i_wr_rgb, i_clear,
      output i_rd_en, i_rd_address, i_rd_col,
      input  o_wr_ready, o_busy, o_rd_rgb_0, o_rd_rgb_1
   );

endinterface

// File: rtl/frame_buffer_bank.sv
// One half of the panel image: 1R1W synchronous memory whose registered
// read data holds its value while i_re is low.
module frame_buffer_bank
   import frame_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 3,
   parameter int unsigned AW    = 8
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q, rdata_d;

   always_comb rdata_d = i_re ? mem_q[i_raddr] : rdata_q;

   always_ff @(posedge i_clock) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) rdata_q <= '0;
      else            rdata_q <= rdata_d;
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Two-bank pixel store feeding the LED scan driver, with self-clear.
// Define FRAME_BUFFER_RMW_EN to add OR / AND-NOT / XOR read-modify-write ops.
module frame_buffer
   import frame_buffer_pkg::*;
#(
   parameter int unsigned COLS        = 32,
   parameter int unsigned ROWS        = 16,
   parameter int unsigned COLOR_DEPTH = 1
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   frame_buffer_if.slave bus
);

   localparam int unsigned COL_BITS     = bits_for(COLS - 1);
   localparam int unsigned ADDRESS_BITS = bits_for(ROWS / 2 - 1);
   localparam int unsigned PIX_W        = 3 * COLOR_DEPTH;
   localparam int unsigned IDX_W        = ADDRESS_BITS + COL_BITS;
   localparam int unsigned DEPTH        = COLS * ROWS / 2;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic             busy_q, busy_d;

   logic [1:0]       we, re;
   logic [IDX_W-1:0] waddr, raddr, wr_idx, scan_idx;
   logic [PIX_W-1:0] wdata, rdata_0, rdata_1, rd_rgb_0, rd_rgb_1;
   logic             wr_bank;

   assign wr_idx   = {bus.i_wr_y[ADDRESS_BITS-1:0], bus.i_wr_x};
   assign wr_bank  = bus.i_wr_y[ADDRESS_BITS];  // y >= ROWS/2 selects bottom
   assign scan_idx = {bus.i_rd_address, bus.i_rd_col};

`ifdef FRAME_BUFFER_RMW_EN
   logic [IDX_W-1:0] rmw_idx_q, rmw_idx_d;
   logic             rmw_bank_q, rmw_bank_d;
   wr_op_e           rmw_op_q, rmw_op_d;
   logic [PIX_W-1:0] rmw_rgb_q, rmw_rgb_d, old_word;
   logic             scan_sel_q, scan_sel_d;
   logic [PIX_W-1:0] hold_0_q, hold_0_d, hold_1_q, hold_1_d;

   // The RMW read reuses the bank read port, so the last scan result is
   // parked in hold_* and presented until the next scan read.
   assign rd_rgb_0 = scan_sel_q ? rdata_0 : hold_0_q;
   assign rd_rgb_1 = scan_sel_q ? rdata_1 : hold_1_q;
   assign old_word = rmw_bank_q ? rdata_1 : rdata_0;
`else
   assign rd_rgb_0 = rdata_0;
   assign rd_rgb_1 = rdata_1;
`endif

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      we      = '0;
      waddr   = wr_idx;
      wdata   = bus.i_wr_rgb;
      re      = {2{bus.i_rd_en}};
      raddr   = scan_idx;
`ifdef FRAME_BUFFER_RMW_EN
      rmw_idx_d  = rmw_idx_q;
      rmw_bank_d = rmw_bank_q;
      rmw_op_d   = rmw_op_q;
      rmw_rgb_d  = rmw_rgb_q;
      scan_sel_d = scan_sel_q | bus.i_rd_en;
      hold_0_d   = hold_0_q;
      hold_1_d   = hold_1_q;
`endif
      case (state_q)
         ST_CLEAR: begin
            we    = '1;
            waddr = k_q;
            wdata = '0;
            k_d   = k_q + IDX_W'(1);
            if (k_q == '1) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.i_clear) begin
               state_d = ST_CLEAR;
               k_d     = '0;
            end else if (bus.i_wr_valid) begin
`ifdef FRAME_BUFFER_RMW_EN
               if (bus.i_wr_op != OP_REPLACE) begin
                  rmw_idx_d  = wr_idx;
                  rmw_bank_d = wr_bank;
                  rmw_op_d   = bus.i_wr_op;
                  rmw_rgb_d  = bus.i_wr_rgb;
                  state_d    = ST_RMW_RD;
               end else
`endif
               we[wr_bank] = 1'b1;
            end
         end
`ifdef FRAME_BUFFER_RMW_EN
         ST_RMW_RD: begin
            if (!bus.i_rd_en) begin
               re[rmw_bank_q] = 1'b1;
               raddr          = rmw_idx_q;
               scan_sel_d     = 1'b0;
               hold_0_d       = rd_rgb_0;
               hold_1_d       = rd_rgb_1;
               state_d        = ST_RMW_WR;
            end
         end
         ST_RMW_WR: begin
            we[rmw_bank_q] = 1'b1;
            waddr          = rmw_idx_q;
            case (rmw_op_q)
               OP_OR:   wdata = old_word | rmw_rgb_q;
               OP_ANDN: wdata = old_word & ~rmw_rgb_q;
               OP_XOR:  wdata = old_word ^ rmw_rgb_q;
               default: wdata = rmw_rgb_q;
            endcase
            state_d = ST_IDLE;
         end
`endif
         default: state_d = ST_CLEAR;
      endcase
      busy_d = (state_d == ST_CLEAR);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q    <= ST_CLEAR;
         k_q        <= '0;
         busy_q     <= 1'b1;
`ifdef FRAME_BUFFER_RMW_EN
         rmw_idx_q  <= '0;
         rmw_bank_q <= 1'b0;
         rmw_op_q   <= OP_REPLACE;
         rmw_rgb_q  <= '0;
         scan_sel_q <= 1'b1;
         hold_0_q   <= '0;
         hold_1_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         busy_q     <= busy_d;
`ifdef FRAME_BUFFER_RMW_EN
         rmw_idx_q  <= rmw_idx_d;
         rmw_bank_q <= rmw_bank_d;
         rmw_op_q   <= rmw_op_d;
         rmw_rgb_q  <= rmw_rgb_d;
         scan_sel_q <= scan_sel_d;
         hold_0_q   <= hold_0_d;
         hold_1_q   <= hold_1_d;
`endif
      end
   end

   assign bus.o_wr_ready = (state_q == ST_IDLE) && !bus.i_clear;
   assign bus.o_busy     = busy_q;
   assign bus.o_rd_rgb_0 = rd_rgb_0;
   assign bus.o_rd_rgb_1 = rd_rgb_1;

   frame_buffer_bank #(.DEPTH(DEPTH), .WIDTH(PIX_W), .AW(IDX_W)) u_bank_top (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_we      (we[0]),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .i_re      (re[0]),
      .i_raddr   (raddr),
      .o_rdata   (rdata_0)
   );

   frame_buffer_bank #(.DEPTH(DEPTH), .WIDTH(PIX_W), .AW(IDX_W)) u_bank_bot (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_we      (we[1]),
      .i_waddr   (waddr),
      .i_wdata   (wdata),
      .i_re      (re[1]),
      .i_raddr   (raddr),
      .o_rdata   (rdata_1)
   );

endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer: an image-array model predicts every scan
// read; a monitor pops predictions when read data appears. Honors FRAME_BUFFER_RMW_EN.
module tb_frame_buffer;
   import frame_buffer_pkg::*;

   localparam int unsigned COLS        = 32;
   localparam int unsigned ROWS        = 16;
   localparam int unsigned COLOR_DEPTH = 1;
   localparam int unsigned HALF        = ROWS / 2;
   localparam int unsigned DEPTH       = COLS * HALF;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   frame_buffer_if #(.COLS(COLS), .ROWS(ROWS), .COLOR_DEPTH(COLOR_DEPTH)) bus ();

   frame_buffer #(.COLS(COLS), .ROWS(ROWS), .COLOR_DEPTH(COLOR_DEPTH)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   typedef struct packed {
      logic [2:0] p0;
      logic [2:0] p1;
   } rd_exp_t;

   rd_exp_t    exp_q[$];
   logic [2:0] img [ROWS][COLS];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         clr_left  = 0;
   int         rmw_phase = 0;   // 0 none, 1 waiting for a free read cycle, 2 writing
   int         rmw_x, rmw_y;
   logic [1:0] rmw_op;
   logic [2:0] rmw_rgb;

   function automatic logic [2:0] pix(input logic r, input logic g, input logic b);
      logic [2:0] p;
      p = '0;
      p[ch_lsb(CH_R, COLOR_DEPTH)] = r;
      p[ch_lsb(CH_G, COLOR_DEPTH)] = g;
      p[ch_lsb(CH_B, COLOR_DEPTH)] = b;
      return p;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic zero_img();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            img[r][c] = '0;
   endtask

   // Monitor: read data appears after the edge that saw i_rd_en.
   initial begin
      logic    pend;
      rd_exp_t e, last;
      last = '0;
      forever begin
         @(posedge clk);
         pend = bus.i_rd_en && rst_n;
         @(negedge clk);
         if (!rst_n) begin
            last = '0;
         end else if (pend) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL rd_underflow: read data with no prediction at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               check("rd_rgb_0", bus.o_rd_rgb_0, e.p0);
               check("rd_rgb_1", bus.o_rd_rgb_1, e.p1);
               last = e;
            end
         end else begin
            check("hold_rgb_0", bus.o_rd_rgb_0, last.p0);
            check("hold_rgb_1", bus.o_rd_rgb_1, last.p1);
         end
      end
   end

   // One clock cycle, entered and left at a falling edge.
   task automatic cyc(input logic rd, input int addr, input int col, input logic wv,
                      input int x, input int y, input logic [2:0] rgb, input logic [1:0] op,
                      input logic clr, output logic taken);
      logic exp_ready;
      bus.i_rd_en        = rd;
      bus.i_rd_address   = 3'(addr);
      bus.i_rd_col       = 5'(col);
      bus.i_wr_valid     = wv;
      bus.i_wr_x         = 5'(x);
      bus.i_wr_y         = 4'(y);
      bus.i_wr_rgb       = rgb;
`ifdef FRAME_BUFFER_RMW_EN
      bus.i_wr_op        = wr_op_e'(op);
`endif
      bus.i_clear        = clr;
      if (rd) exp_q.push_back(rd_exp_t'{p0: img[addr][col], p1: img[addr + HALF][col]});
      exp_ready = (clr_left == 0) && (rmw_phase == 0) && !clr;
      #1;
      check("wr_ready", bus.o_wr_ready, exp_ready);
      check("busy", bus.o_busy, clr_left > 0);
      taken = wv && exp_ready;
      if (clr_left > 0) begin
         clr_left--;
      end else if (rmw_phase == 2) begin
         case (rmw_op)
            2'b01:   img[rmw_y][rmw_x] = img[rmw_y][rmw_x] | rmw_rgb;
            2'b10:   img[rmw_y][rmw_x] = img[rmw_y][rmw_x] & ~rmw_rgb;
            default: img[rmw_y][rmw_x] = img[rmw_y][rmw_x] ^ rmw_rgb;
         endcase
         rmw_phase = 0;
      end else if (rmw_phase == 1) begin
         if (!rd) rmw_phase = 2;
      end else if (clr) begin
         clr_left = DEPTH;
         zero_img();
      end else if (taken) begin
`ifdef FRAME_BUFFER_RMW_EN
         if (op != 2'b00) begin
            rmw_x = x; rmw_y = y; rmw_op = op; rmw_rgb = rgb;
            rmw_phase = 1;
         end else
`endif
         img[y][x] = rgb;
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      logic t;
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, '0, '0, 0, t);
   endtask

   task automatic rd(input int a, input int c);
      logic t;
      cyc(1, a, c, 0, 0, 0, '0, '0, 0, t);
   endtask

   task automatic write_px(input int x, input int y, input logic [2:0] rgb, input logic [1:0] op);
      logic t;
      int   n;
      t = 0;
      n = 0;
      while (!t && n < 600) begin
         cyc(0, 0, 0, 1, x, y, rgb, op, 0, t);
         n++;
      end
      if (!t) begin
         n_cmp++;
         n_bad++;
         $display("FAIL write_timeout: not taken after %0d cycles, expected acceptance", n);
      end
   endtask

   task automatic settle();
      for (int n = 0; n < 20 && rmw_phase != 0; n++) idle(1);
   endtask

   task automatic do_reset();
      bus.i_rd_en    = 0;
      bus.i_wr_valid = 0;
      bus.i_clear    = 0;
      rst_n          = 1'b0;
      #1;
      check("rst_busy", bus.o_busy, 1);
      check("rst_ready", bus.o_wr_ready, 0);
      check("rst_rgb_0", bus.o_rd_rgb_0, 0);
      check("rst_rgb_1", bus.o_rd_rgb_1, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      clr_left  = DEPTH;
      rmw_phase = 0;
      zero_img();
   endtask

`ifdef FRAME_BUFFER_RMW_EN
   task automatic rmw_seq(input logic stall);
      logic [2:0] v [4];
      logic [1:0] o [4];
      v = '{3'b001, 3'b010, 3'b001, 3'b110};
      o = '{2'b00, 2'b01, 2'b10, 2'b11};
      for (int i = 0; i < 4; i++) begin
         write_px(31, 15, v[i], o[i]);
         if (stall && i > 0)
            for (int s = 0; s < 4; s++) rd(7, 31);
         settle();
      end
      rd(7, 31);
      idle(1);
   endtask
`endif

   initial begin
      logic t;
      bus.i_wr_x = '0; bus.i_wr_y = '0; bus.i_wr_rgb = '0;
      bus.i_rd_address = '0; bus.i_rd_col = '0;
      bus.i_rd_en = 0; bus.i_wr_valid = 0; bus.i_clear = 0;
`ifdef FRAME_BUFFER_RMW_EN
      bus.i_wr_op = OP_REPLACE;
`endif
      zero_img();
      #2;
      do_reset();

      // clear after reset, then sweep every address
      idle(DEPTH);
      for (int a = 0; a < HALF; a++)
         for (int c = 0; c < COLS; c++) rd(a, c);
      idle(1);

      // replace writes into both halves
      write_px(5, 3, pix(0, 1, 0), 2'b00);
      write_px(5, 11, pix(0, 0, 1), 2'b00);
      rd(3, 5);
      idle(1);

      // same-cycle write/read collision, then follow-up read
      cyc(1, 0, 0, 1, 0, 0, 3'b111, 2'b00, 0, t);
      rd(0, 0);
      idle(1);

      // clear has priority over a simultaneous write
      cyc(0, 0, 0, 1, 7, 9, 3'b011, 2'b00, 1, t);
      write_px(7, 9, 3'b011, 2'b00);
      rd(1, 7);
      rd(3, 5);
      idle(1);

`ifdef FRAME_BUFFER_RMW_EN
      rmw_seq(1'b0);
      rmw_seq(1'b1);
`endif

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic r, w, c;
         r = ($urandom_range(1) == 1) && (clr_left == 0);
         w = ($urandom_range(2) == 0);
         c = ($urandom_range(299) == 0);
         cyc(r, $urandom_range(HALF - 1), $urandom_range(COLS - 1), w,
             $urandom_range(COLS - 1), $urandom_range(ROWS - 1), 3'($urandom),
             2'($urandom), c, t);
      end
      idle(clr_left + 2);

      // reset in the middle of a clear restarts it from the beginning
      cyc(0, 0, 0, 0, 0, 0, '0, '0, 1, t);
      idle(100);
      do_reset();
      idle(DEPTH);
      rd(1, 7);
      idle(2);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL rd_leftover: %0d predictions unconsumed, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
